// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary-to-BCD converter with start/busy/done handshake.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, ADJ, SHIFT} state_t;
  state_t          state;
  logic [WIDTH-1:0] sh_bin;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    cnt;
  logic             ovf_acc;
  logic             ovf_nxt;
  logic [BW-1:0]    scr_nxt;
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = scratch[4*i+:4] >= 4'd5 ? scratch[4*i+:4] + 4'd3 : scratch[4*i+:4];
  end
  assign scr_nxt = {scratch[BW-2:0], sh_bin[WIDTH-1]};
  assign ovf_nxt = ovf_acc | scratch[BW-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sh_bin  <= '0;
      scratch <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sh_bin  <= bin;
          scratch <= '0;
          cnt     <= CW'(WIDTH);
          ovf_acc <= 1'b0;
          busy    <= 1'b1;
          state   <= ADJ;
        end
        ADJ: begin
          scratch <= adj;
          state   <= SHIFT;
        end
        SHIFT: begin
          scratch <= scr_nxt;
          sh_bin  <= sh_bin << 1;
          ovf_acc <= ovf_nxt;
          cnt     <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            bcd   <= scr_nxt;
            ovf   <= ovf_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else state <= ADJ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: randomized and directed checks of bin2bcd_seq against an arithmetic decimal model.
module tb_bin2bcd_seq;
  logic clk = 0, rst_n = 0;
  logic start = 0, start2 = 0;
  logic [7:0] bin = 0, bin2 = 0;
  logic busy, done, ovf, busy2, done2, ovf2;
  logic [11:0] bcd;
  logic [7:0] bcd2;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (.clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf));
  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2));

  function automatic logic [11:0] ref_bcd(input int v);
    return 12'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic conv(input bit s2, input logic [7:0] v, input bit disturb,
                      output logic [11:0] b, output logic o, output int lat,
                      output bit busy_ok, output logic done_after);
    tick();
    if (s2) begin start2 = 1; bin2 = v; end else begin start = 1; bin = v; end
    tick();
    start = 0; start2 = 0;
    lat = 0; busy_ok = 1;
    while (!(s2 ? done2 : done) && lat < 40) begin
      if (!(s2 ? busy2 : busy)) busy_ok = 0;
      if (disturb && lat == 5) begin start = 1; bin = 8'hFF; end
      if (disturb && lat == 6) start = 0;
      tick();
      lat++;
    end
    if (s2 ? busy2 : busy) busy_ok = 0;
    b = s2 ? {4'h0, bcd2} : bcd;
    o = s2 ? ovf2 : ovf;
    tick();
    done_after = s2 ? done2 : done;
  endtask

  task automatic test_reset();
    tick(); tick();
    total++;
    if ({busy, done, ovf, bcd} !== 15'd0) begin bad++;
      $display("FAIL reset_outputs got=%h exp=0", {busy, done, ovf, bcd}); end
    start = 1; bin = 8'd5;
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL start_in_reset busy=%b exp=0", busy); end
    rst_n = 1;
    tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL start_after_release busy=%b exp=1", busy); end
    start = 0;
    for (int i = 0; i < 20 && busy; i++) tick();
    tick();
  endtask

  task automatic test_basic();
    logic [11:0] b; logic o, da; int lat; bit bk;
    logic [7:0] vals[2] = '{8'h20, 8'h10};
    foreach (vals[i]) begin
      conv(0, vals[i], 0, b, o, lat, bk, da);
      total += 5;
      if (b !== ref_bcd(vals[i])) begin bad++; $display("FAIL basic_bcd v=%0d got=%h exp=%h", vals[i], b, ref_bcd(vals[i])); end
      if (o !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", o); end
      if (lat !== 16) begin bad++; $display("FAIL basic_latency got=%0d exp=16", lat); end
      if (!bk) begin bad++; $display("FAIL basic_busy got=0 exp=1 throughout"); end
      if (da !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", da); end
    end
  endtask

  task automatic test_sweep();
    logic [11:0] b; logic o, da; int lat; bit bk;
    int bnd[6] = '{0, 9, 10, 99, 100, 255};
    foreach (bnd[i]) begin
      conv(0, 8'(bnd[i]), 0, b, o, lat, bk, da);
      total++;
      if (b !== ref_bcd(bnd[i])) begin bad++; $display("FAIL boundary v=%0d got=%h exp=%h", bnd[i], b, ref_bcd(bnd[i])); end
    end
    for (int v = 0; v < 256; v++) begin
      conv(0, 8'(v), 0, b, o, lat, bk, da);
      total += 3;
      if (b !== ref_bcd(v)) begin bad++; $display("FAIL sweep_bcd v=%0d got=%h exp=%h", v, b, ref_bcd(v)); end
      if (o !== 1'b0) begin bad++; $display("FAIL sweep_ovf v=%0d got=%b exp=0", v, o); end
      if (lat !== 16 || da !== 1'b0) begin bad++; $display("FAIL sweep_done v=%0d lat=%0d after=%b exp 16/0", v, lat, da); end
    end
    for (int k = 0; k < 20; k++) begin
      int v = int'($urandom_range(0, 255));
      conv(0, 8'(v), 0, b, o, lat, bk, da);
      total++;
      if (b !== ref_bcd(v)) begin bad++; $display("FAIL random v=%0d got=%h exp=%h", v, b, ref_bcd(v)); end
    end
  endtask

  task automatic test_ignore_busy();
    logic [11:0] b; logic o, da; int lat; bit bk;
    conv(0, 8'd123, 1, b, o, lat, bk, da);
    total += 3;
    if (b !== 12'h123) begin bad++; $display("FAIL ignore_bcd got=%h exp=123", b); end
    if (lat !== 16) begin bad++; $display("FAIL ignore_latency got=%0d exp=16", lat); end
    if (da !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ignore_second_done done=%b busy=%b exp=0/0", da, busy); end
  endtask

  task automatic test_back_to_back();
    int hits[$];
    tick();
    start = 1; bin = 8'd77;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (done) begin
        hits.push_back(c);
        total++;
        if (bcd !== 12'h077) begin bad++; $display("FAIL b2b_bcd got=%h exp=077", bcd); end
      end
    end
    start = 0;
    total++;
    if (hits.size() < 3) begin bad++; $display("FAIL b2b_count got=%0d exp>=3", hits.size()); end
    else for (int i = 1; i < hits.size(); i++) begin
      total++;
      if (hits[i] - hits[i-1] !== 17) begin bad++; $display("FAIL b2b_period got=%0d exp=17", hits[i] - hits[i-1]); end
    end
    for (int i = 0; i < 20 && busy; i++) tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [11:0] b; logic o, da; int lat; bit bk; int seen;
    tick();
    start = 1; bin = 8'd200;
    tick();
    start = 0;
    for (int i = 0; i < 8; i++) tick();
    rst_n = 0;
    #1;
    total++;
    if ({busy, done, ovf, bcd} !== 15'd0) begin bad++; $display("FAIL reset_mid got=%h exp=0", {busy, done, ovf, bcd}); end
    tick();
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (done) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL reset_mid_no_done got=%0d exp=0", seen); end
    conv(0, 8'd45, 0, b, o, lat, bk, da);
    total++;
    if (b !== 12'h045) begin bad++; $display("FAIL reset_mid_next got=%h exp=045", b); end
  endtask

  task automatic test_digits2();
    logic [11:0] b; logic o, da; int lat; bit bk;
    int vals[4] = '{99, 200, 42, 100};
    foreach (vals[i]) begin
      conv(1, 8'(vals[i]), 0, b, o, lat, bk, da);
      total += 2;
      if (o !== (vals[i] > 99)) begin bad++; $display("FAIL d2_ovf v=%0d got=%b exp=%b", vals[i], o, vals[i] > 99); end
      if (vals[i] <= 99 && b[7:0] !== ref_bcd(vals[i]) >> 0 & 12'hFF) begin bad++; $display("FAIL d2_bcd v=%0d got=%h exp=%h", vals[i], b[7:0], ref_bcd(vals[i]) & 12'hFF); end
      else if (vals[i] > 99 && lat !== 16) begin bad++; $display("FAIL d2_latency got=%0d exp=16", lat); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_digits2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter controller: the iterative, clocked counterpart of the combinational `bin2bcd` datapath. It accepts a binary value on a start strobe and runs the shift-add-3 (double-dabble) algorithm one step per clock under a small FSM. It returns packed BCD digits with a one-cycle `done` pulse. It sits between the switch/counter logic and the seven-segment display driver, and is used where a registered, handshaked result is needed instead of a wide combinational adder tree.

## Interface

**Parameters**
- `WIDTH`, default 8: width of the binary input.
- `DIGITS`, default 3: number of BCD digits produced (4 bits each).

**Ports**
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: conversion request; sampled on each rising edge.
- `bin`, input, `WIDTH`: binary operand; captured only on an accepted `start`.
- `busy`, output, 1: high while a conversion is in progress.
- `done`, output, 1: single-cycle pulse marking that `bcd`/`ovf` were just updated.
- `bcd`, output, `4*DIGITS`: packed result; bits [3:0] are units, [7:4] tens, and so on.
- `ovf`, output, 1: result did not fit in `DIGITS` digits; registered with `bcd`.

## Operation

**Reset** (asynchronous assert, `rst_n` = 0):
- FSM goes to IDLE.
- `busy`, `done`, `ovf` = 0; `bcd` = 0; internal shift registers and counter cleared.
- Deassertion is synchronous to `clk` through the normal register path.

**Registers**
- `sh_bin` (`WIDTH`): holds the captured operand.
- `scratch` (`4*DIGITS`): BCD accumulator.
- `cnt`: bits remaining, sized `$clog2(WIDTH+1)`.
- `ovf_acc`: overflow accumulator.

**FSM**
- **IDLE**
  - If `start` = 1: `sh_bin` ← `bin`, `scratch` ← 0, `cnt` ← `WIDTH`, `ovf_acc` ← 0, go to ADJ.
  - Otherwise stay in IDLE.
- **ADJ**
  - Each 4-bit digit of `scratch` that is ≥ 5 has 3 added to it; digits ≤ 4 are unchanged.
  - Go to SHIFT.
- **SHIFT**
  - `{scratch, sh_bin}` shifts left by 1.
  - The bit shifted out of the MSB of `scratch` is ORed into `ovf_acc`.
  - `cnt` ← `cnt` − 1.
  - If the new `cnt` is 0: `bcd` ← shifted `scratch`, `ovf` ← the updated `ovf_acc`, `done` ← 1, go to IDLE.
  - Otherwise go to ADJ.

**Outputs and handshake**
- `busy` is high exactly when the state is ADJ or SHIFT.
- `start` is ignored while `busy` = 1. `bin` changes during a conversion have no effect.
- `bcd` and `ovf` hold their values between completions. They change only on the edge that raises `done`.
- `done` is high for exactly one cycle, then returns to 0.

**Arithmetic**
- Digit adjust is 4-bit modulo addition. With a correct algorithm an adjusted digit never exceeds 12, so it cannot wrap.
- Overflow is only possible when `WIDTH` bits exceed the `DIGITS` capacity. With defaults (8-bit input, max 255, 3 digits) `ovf` is always 0.
- With `DIGITS` = 2, any input > 99 sets `ovf`. In that case `bcd` holds the low two digits of a truncated, invalid result; consumers must qualify `bcd` with `ovf`.

## Timing

**Latency**
- Edge E0 samples `start` = 1 in IDLE.
- ADJ/SHIFT steps occupy edges E1 through E(2·WIDTH).
- `done` = 1 and `bcd` is valid in the cycle after edge E(2·WIDTH): 16 cycles for the defaults.
- `busy` rises after E0 and falls after E(2·WIDTH), in the same cycle `done` rises.

**Throughput**
- `done` coincides with IDLE, so a `start` asserted during the `done` cycle is accepted at the next edge.
- Back-to-back period is therefore 2·WIDTH + 1 cycles.

**Reset mid-conversion**
- Aborts immediately. No `done` pulse is produced.
- The previous `bcd` is cleared to 0.
- A `start` held high across reset deassertion is accepted on the first edge after `rst_n` rises.

**Start at reset**
- `start` asserted at the same edge that reset is released (`rst_n` still 0 at that edge) is not accepted.

## Test plan

1. `bin` = 0x20 (32) with a 1-cycle `start` → `busy` for 16 cycles, then `done` pulse with `bcd` = 0x032, `ovf` = 0. Then `bin` = 0x10 → `bcd` = 0x016.
2. Boundary values 0, 9, 10, 99, 100, 255 → `bcd` = 0x000, 0x009, 0x010, 0x099, 0x100, 0x255. Exhaustive sweep 0–255 checked against a reference model: `ovf` always 0 and `done` exactly once per request.
3. `start` pulsed again and `bin` changed to 0xFF mid-conversion (cycle 5) → ignored; the original result is returned after 16 cycles and only one `done` pulse occurs.
4. `start` held high continuously with `bin` = 77 → `done` every 17 cycles, each time `bcd` = 0x077.
5. `rst_n` pulled low at cycle 8 of a conversion of 200 → `busy`, `done`, `bcd`, `ovf` all 0 immediately. No `done` after release. A new `start` with 45 → `bcd` = 0x045.
6. Instance with `DIGITS` = 2: `bin` = 99 → `bcd` = 0x99, `ovf` = 0. `bin` = 200 → `ovf` = 1 on the `done` cycle.
